// File: rtl/tb_stream_stall_fifo.sv
// In-order {addr, data} stream buffer with optional pseudorandom input backpressure.
// Define TB_STALL_FIFO_STALL_EN to compile in the stall LFSR; otherwise stall_rate_i is ignored.
module tb_stream_stall_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned FifoDepth = 4,
    parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic [AddrWidth-1:0]         in_addr_i,
    input  logic [DataWidth-1:0]         in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [AddrWidth-1:0]         out_addr_o,
    output logic [DataWidth-1:0]         out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    input  logic [3:0]                   stall_rate_i,
    output logic [$clog2(FifoDepth):0]   occupancy_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [AddrWidth-1:0]         xfer_cnt_o
);

    localparam int unsigned IdxW = $clog2(FifoDepth);
    localparam int unsigned PtrW = IdxW + 1;

    logic [AddrWidth-1:0] r_mem_addr [FifoDepth];
    logic [DataWidth-1:0] r_mem_data [FifoDepth];
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [AddrWidth-1:0] r_xfer_cnt;

    logic w_full;
    logic w_empty;
    logic w_stall;
    logic w_push;
    logic w_pop;

    // MSB of each pointer is the wrap bit: equal index with differing wrap means full.
    assign w_full  = (r_wr_ptr[IdxW-1:0] == r_rd_ptr[IdxW-1:0]) &&
                     (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign in_ready_o  = !w_full && !w_stall && !clr_i;
    assign out_valid_o = !w_empty && !clr_i;
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    assign out_addr_o  = r_mem_addr[r_rd_ptr[IdxW-1:0]];
    assign out_data_o  = r_mem_data[r_rd_ptr[IdxW-1:0]];
    assign occupancy_o = r_wr_ptr - r_rd_ptr;
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign xfer_cnt_o  = r_xfer_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_addr[r_wr_ptr[IdxW-1:0]] <= in_addr_i;
            r_mem_data[r_wr_ptr[IdxW-1:0]] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_xfer_cnt <= '0;
        end else if (clr_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PtrW'(1);
                r_xfer_cnt <= r_xfer_cnt + AddrWidth'(1);
            end
        end
    end

`ifdef TB_STALL_FIFO_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci taps 16,14,13,11; frozen while stalling is disabled so the pattern is reproducible.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_stall   = (r_lfsr[3:0] < stall_rate_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= LfsrSeed;
        end else if (clr_i) begin
            r_lfsr <= LfsrSeed;
        end else if (stall_rate_i != 4'd0) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    logic w_unused_stall_rate;
    assign w_unused_stall_rate = ^stall_rate_i;
    assign w_stall             = 1'b0;
`endif

endmodule

// File: tb/tb_tb_stream_stall_fifo.sv
// Scoreboard bench for tb_stream_stall_fifo: accepted beats are queued, a negedge monitor
// pops and compares every delivered beat. Stall checks run only when TB_STALL_FIFO_STALL_EN is defined.
module tb_tb_stream_stall_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i;
    logic [31:0] in_addr_i;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_addr_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  stall_rate_i;
    logic [2:0]  occupancy_o;
    logic        full_o;
    logic        empty_o;
    logic [31:0] xfer_cnt_o;

    tb_stream_stall_fifo dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .in_addr_i(in_addr_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .stall_rate_i(stall_rate_i),
        .occupancy_o(occupancy_o), .full_o(full_o), .empty_o(empty_o), .xfer_cnt_o(xfer_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    lat_chk  = 1'b0;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && in_valid_i && in_ready_o)
            exp_q.push_back('{addr: in_addr_i, data: in_data_i, cyc: cyc});
    end

    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_addr", 64'(out_addr_o), 64'(mon_e.addr));
                chk("sb_data", 64'(out_data_o), 64'(mon_e.data));
                if (lat_chk) chk("latency", 64'(cyc - mon_e.cyc), 64'd1);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_n(input int n, input logic [31:0] a0, input logic [31:0] d0);
        for (int i = 0; i < n; i++) begin
            in_valid_i = 1'b1;
            in_addr_i  = a0 + 32'(i);
            in_data_i  = d0 + 32'(i);
            step();
        end
        in_valid_i = 1'b0;
    endtask

`ifdef TB_STALL_FIFO_STALL_EN
    task automatic capture_stall(output logic [63:0] pat);
        stall_rate_i = 4'd0;
        do_clr();
        stall_rate_i = 4'd8;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_i);
            pat[i] = ~in_ready_o;
        end
        step();
        stall_rate_i = 4'd0;
    endtask
`endif

    initial begin
`ifdef TB_STALL_FIFO_STALL_EN
        logic [63:0] pat_a;
        logic [63:0] pat_b;
        int          sent;
        int          low_cnt;
        logic        acc;
`endif
        rst_ni = 1'b0; clr_i = 1'b0; in_addr_i = '0; in_data_i = '0;
        in_valid_i = 1'b0; out_ready_i = 1'b0; stall_rate_i = 4'd0;
        #2;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_addr", 64'(out_addr_o), 64'd0);
        chk("rst_out_data", 64'(out_data_o), 64'd0);
        chk("rst_occupancy", 64'(occupancy_o), 64'd0);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_xfer", 64'(xfer_cnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Streaming at full rate: 10 beats, one-cycle latency each.
        lat_chk = 1'b1;
        out_ready_i = 1'b1;
        push_n(10, 32'd0, 32'hA0);
        step(2);
        lat_chk = 1'b0;
        chk("stream_xfer", 64'(xfer_cnt_o), 64'd10);
        chk("stream_empty", 64'(empty_o), 64'd1);
        chk("stream_sb_drained", 64'(exp_q.size()), 64'd0);

        // Fill against a blocked sink, then a single pop.
        out_ready_i = 1'b0;
        push_n(6, 32'd100, 32'hB0);
        chk("fill_full", 64'(full_o), 64'd1);
        chk("fill_in_ready", 64'(in_ready_o), 64'd0);
        chk("fill_occupancy", 64'(occupancy_o), 64'd4);
        in_valid_i = 1'b1; in_addr_i = 32'd106; in_data_i = 32'hB6;
        out_ready_i = 1'b1;
        #1;
        chk("no_passthrough", 64'(in_ready_o), 64'd0);
        step();
        out_ready_i = 1'b0;
        in_valid_i = 1'b0;
        chk("pop1_occupancy", 64'(occupancy_o), 64'd3);
        chk("pop1_in_ready", 64'(in_ready_o), 64'd1);
        out_ready_i = 1'b1;
        step(4);
        chk("fill_drain_occ", 64'(occupancy_o), 64'd0);
        chk("fill_drain_xfer", 64'(xfer_cnt_o), 64'd14);

        // Steady state with 2 entries: simultaneous push/pop for 8 cycles.
        out_ready_i = 1'b0;
        push_n(2, 32'd200, 32'hC0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1;
            in_addr_i  = 32'd202 + 32'(i);
            in_data_i  = 32'hC2 + 32'(i);
            step();
            chk("steady_occupancy", 64'(occupancy_o), 64'd2);
        end
        in_valid_i = 1'b0;
        step(3);
        chk("steady_empty", 64'(empty_o), 64'd1);
        chk("steady_xfer", 64'(xfer_cnt_o), 64'd24);

        // Synchronous clear with 3 held entries and 5 delivered.
        do_clr();
        chk("clr0_xfer", 64'(xfer_cnt_o), 64'd0);
        out_ready_i = 1'b1;
        push_n(5, 32'd300, 32'hD0);
        step(2);
        out_ready_i = 1'b0;
        push_n(3, 32'd310, 32'hE0);
        chk("preclr_occ", 64'(occupancy_o), 64'd3);
        chk("preclr_xfer", 64'(xfer_cnt_o), 64'd5);
        clr_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
        #1;
        chk("clr_in_ready", 64'(in_ready_o), 64'd0);
        chk("clr_out_valid", 64'(out_valid_o), 64'd0);
        step();
        clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        exp_q.delete();
        chk("postclr_occ", 64'(occupancy_o), 64'd0);
        chk("postclr_xfer", 64'(xfer_cnt_o), 64'd0);
        chk("postclr_empty", 64'(empty_o), 64'd1);

`ifdef TB_STALL_FIFO_STALL_EN
        capture_stall(pat_a);
        capture_stall(pat_b);
        chk("stall_repeat", pat_b, pat_a);
        chk("stall_nonzero", 64'(pat_a != 64'd0), 64'd1);

        do_clr();
        stall_rate_i = 4'd8;
        out_ready_i  = 1'b1;
        sent = 0;
        low_cnt = 0;
        for (int c = 0; c < 5000 && sent < 1000; c++) begin
            in_valid_i = 1'b1;
            in_addr_i  = 32'h1000 + 32'(sent);
            in_data_i  = 32'(sent);
            @(negedge clk_i);
            acc = in_ready_o;
            if (c < 1000 && !acc) low_cnt++;
            @(posedge clk_i);
            #1;
            if (acc) sent++;
        end
        in_valid_i = 1'b0;
        stall_rate_i = 4'd0;
        step(4);
        chk("stall_sent", 64'(sent), 64'd1000);
        chk("stall_delivered", 64'(xfer_cnt_o), 64'd1000);
        chk("stall_low_in_range", 64'(low_cnt >= 400 && low_cnt <= 600), 64'd1);
        chk("stall_sb_drained", 64'(exp_q.size()), 64'd0);
        out_ready_i = 1'b0;
`endif

        // Asynchronous reset mid-stream with 2 held entries.
        do_clr();
        push_n(2, 32'h600, 32'h60);
        chk("prerst_occ", 64'(occupancy_o), 64'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_out_valid", 64'(out_valid_o), 64'd0);
        chk("arst_out_data", 64'(out_data_o), 64'd0);
        chk("arst_out_addr", 64'(out_addr_o), 64'd0);
        chk("arst_occ", 64'(occupancy_o), 64'd0);
        chk("arst_empty", 64'(empty_o), 64'd1);
        chk("arst_in_ready", 64'(in_ready_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        push_n(1, 32'h77, 32'h55);
        chk("postrst_valid", 64'(out_valid_o), 64'd1);
        chk("postrst_data", 64'(out_data_o), 64'h55);
        chk("postrst_occ", 64'(occupancy_o), 64'd1);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("postrst_empty", 64'(empty_o), 64'd1);
        chk("postrst_xfer", 64'(xfer_cnt_o), 64'd1);

        step(2);
        chk("final_sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
